// File: rtl/ball_scheduler.sv
// ball_scheduler: game sequencer for the falling-ball datapath.
// Owns four ball slots, spawns balls on a fixed tick interval, moves them on a
// divided clock tick, judges button presses against the hit zone and keeps
// score and miss counts until too many balls are missed.
module ball_scheduler #(
  parameter int TICK_DIV    = 500000,
  parameter int SPAWN_TICKS = 40,
  parameter int Y_START     = 0,
  parameter int Y_END       = 779,
  parameter int ZONE_TOP    = 400,
  parameter int ZONE_BOT    = 475,
  parameter int MAX_MISSES  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        button,
  output logic [39:0] ball_y,
  output logic [3:0]  ball_active,
  output logic [15:0] score,
  output logic [7:0]  misses,
  output logic        game_over,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic        spawn_drop
);

  localparam int NumSlots = 4;
  localparam int TickW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SpawnW   = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;

  localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [SpawnW-1:0] SpawnLast = SpawnW'(SPAWN_TICKS - 1);
  localparam logic [9:0]        YStart    = 10'(Y_START);
  localparam logic [9:0]        YEnd      = 10'(Y_END);
  localparam logic [9:0]        ZoneTop   = 10'(ZONE_TOP);
  localparam logic [9:0]        ZoneBot   = 10'(ZONE_BOT);
  localparam logic [7:0]        MaxMisses = 8'(MAX_MISSES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t                    state;
  logic [TickW-1:0]          tickCnt;
  logic [SpawnW-1:0]         spawnCnt;
  logic                      buttonPrev;
  logic [NumSlots-1:0][9:0]  slotY;

  logic                      running;
  logic                      tick;
  logic                      spawnFire;
  logic                      pressed;
  logic                      hitNow;
  logic                      hitFound;
  logic [1:0]                hitIdx;
  logic [9:0]                bestY;
  logic                      freeFound;
  logic [1:0]                freeIdx;
  logic [2:0]                missCount;
  logic [NumSlots-1:0][9:0]  nextY;
  logic [NumSlots-1:0]       nextActive;
  logic [8:0]                missSum;
  logic [7:0]                nextMisses;

  assign ball_y    = slotY;
  assign game_over = (state == OVER);
  assign running   = (state == RUN);
  assign tick      = running && (tickCnt == TickLast);
  assign spawnFire = tick && (spawnCnt == SpawnLast);
  assign pressed   = running && button && !buttonPrev;
  assign hitNow    = pressed && hitFound;

  // Hit judging: among active in-zone balls pick the lowest on screen
  // (largest y); a strict compare keeps the lower index on a tie.
  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    hitFound = 1'b0;
    hitIdx   = '0;
    bestY    = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (ball_active[i] && (slotY[i] >= ZoneTop) && (slotY[i] <= ZoneBot) &&
          (!hitFound || (slotY[i] > bestY))) begin
        hitFound = 1'b1;
        hitIdx   = 2'(i);
        bestY    = slotY[i];
      end
    end
  end

  // Spawn target: lowest-index slot that is free at the start of the cycle,
  // so a slot released this cycle by a hit or miss is never reused at once.
  always_comb begin
    freeFound = 1'b0;
    freeIdx   = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!ball_active[i]) begin
        freeFound = 1'b1;
        freeIdx   = 2'(i);
      end
    end
  end

  // Next slot contents: movement and misses on a tick, hit removal, then spawn.
  always_comb begin
    nextY      = slotY;
    nextActive = ball_active;
    missCount  = '0;
    if (tick) begin
      for (int i = 0; i < NumSlots; i++) begin
        // The slot taken by a hit this cycle is removed, not advanced.
        if (ball_active[i] && !(hitNow && (hitIdx == 2'(i)))) begin
          if (slotY[i] == YEnd) begin
            nextActive[i] = 1'b0;
            missCount     = missCount + 3'd1;
          end else begin
            nextY[i] = slotY[i] + 10'd1;
          end
        end
      end
    end
    if (hitNow) begin
      nextActive[hitIdx] = 1'b0;
    end
    if (spawnFire && freeFound) begin
      nextActive[freeIdx] = 1'b1;
      nextY[freeIdx]      = YStart;
    end
    missSum    = {1'b0, misses} + {6'd0, missCount};
    nextMisses = missSum[8] ? 8'hFF : missSum[7:0];
  end

  // Game FSM plus every registered counter, slot and pulse output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the slot array is plain control state, so it is reset like any other register.
      state       <= IDLE;
      tickCnt     <= '0;
      spawnCnt    <= '0;
      buttonPrev  <= 1'b0;
      slotY       <= '0;
      ball_active <= '0;
      score       <= '0;
      misses      <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      spawn_drop  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      buttonPrev <= button;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      spawn_drop <= 1'b0;
      unique case (state)
        IDLE, OVER: begin
          if (start) begin
            state       <= RUN;
            tickCnt     <= '0;
            spawnCnt    <= '0;
            slotY       <= '0;
            ball_active <= '0;
            score       <= '0;
            misses      <= '0;
          end
        end
        RUN: begin
          tickCnt <= tick ? '0 : tickCnt + 1'b1;
          if (tick) begin
            spawnCnt <= spawnFire ? '0 : spawnCnt + 1'b1;
          end
          slotY       <= nextY;
          ball_active <= nextActive;
          misses      <= nextMisses;
          miss_pulse  <= (missCount != 3'd0);
          spawn_drop  <= spawnFire && !freeFound;
          if (hitNow) begin
            hit_pulse <= 1'b1;
            if (score != 16'hFFFF) begin
              score <= score + 16'd1;
            end
          end
          // Hits and spawns of this cycle are kept; the game ends on this edge.
          if (nextMisses >= MaxMisses) begin
            state <= OVER;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_scheduler.sv
// tb_ball_scheduler: directed tests for ball_scheduler with a small game
// configuration (tick every 2 clocks, spawn every 4 ticks, Y_END=20, zone 10..14,
// 3 misses end the game). Edge E0 is the edge that enters RUN; in this
// configuration tick effects land on even edges and spawns on multiples of 8.
module tb_ball_scheduler;

  logic        clk;
  logic        reset;
  logic        start;
  logic        button;
  logic [39:0] ball_y;
  logic [3:0]  ball_active;
  logic [15:0] score;
  logic [7:0]  misses;
  logic        game_over;
  logic        hit_pulse;
  logic        miss_pulse;
  logic        spawn_drop;

  int vectors = 0;
  int errors  = 0;
  int t       = 0;

  ball_scheduler #(
    .TICK_DIV   (2),
    .SPAWN_TICKS(4),
    .Y_START    (0),
    .Y_END      (20),
    .ZONE_TOP   (10),
    .ZONE_BOT   (14),
    .MAX_MISSES (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .button     (button),
    .ball_y     (ball_y),
    .ball_active(ball_active),
    .score      (score),
    .misses     (misses),
    .game_over  (game_over),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .spawn_drop (spawn_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 time unit after edge number 'target' of the current game.
  task automatic adv_to(input int target);
    while (t < target) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  // Reset, then start a game; returns 1 unit after E0 with t=0.
  task automatic start_game();
    reset  = 1'b1;
    start  = 1'b0;
    button = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    button = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({ball_active, ball_y} !== 44'd0) begin
      errors++;
      $display("FAIL reset_slots: active=%b y=%h expected all zero", ball_active, ball_y);
    end
    vectors++;
    if ({score, misses, game_over, hit_pulse, miss_pulse, spawn_drop} !== 28'd0) begin
      errors++;
      $display("FAIL reset_status: score=%0d misses=%0d over=%b pulses=%b%b%b expected all zero",
               score, misses, game_over, hit_pulse, miss_pulse, spawn_drop);
    end
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if ({ball_active, game_over} !== 5'd0) begin
      errors++;
      $display("FAIL idle_hold: active=%b over=%b expected 0000/0", ball_active, game_over);
    end
  endtask

  task automatic test_spawn();
    start_game();
    for (int k = 1; k <= 7; k++) begin
      adv_to(k);
      vectors++;
      if (ball_active !== 4'b0000) begin
        errors++;
        $display("FAIL spawn_wait t=%0d: active=%b expected 0000", t, ball_active);
      end
    end
    for (int k = 8; k <= 10; k++) begin
      adv_to(k);
      vectors++;
      if (ball_active !== 4'b0001 || ball_y[9:0] !== ((k == 10) ? 10'd1 : 10'd0)) begin
        errors++;
        $display("FAIL spawn_first t=%0d: active=%b y0=%0d expected 0001 y0=%0d",
                 t, ball_active, ball_y[9:0], (k == 10) ? 1 : 0);
      end
      vectors++;
      if ({hit_pulse, miss_pulse, spawn_drop} !== 3'b000) begin
        errors++;
        $display("FAIL spawn_pulses t=%0d: pulses=%b%b%b expected 000",
                 t, hit_pulse, miss_pulse, spawn_drop);
      end
    end
  endtask

  task automatic test_miss_and_over();
    start_game();
    adv_to(40);
    vectors++;
    if (spawn_drop !== 1'b1 || ball_active !== 4'b1111) begin
      errors++;
      $display("FAIL drop_pulse: drop=%b active=%b expected 1/1111", spawn_drop, ball_active);
    end
    adv_to(41);
    vectors++;
    if (spawn_drop !== 1'b0 || ball_active !== 4'b1111) begin
      errors++;
      $display("FAIL drop_clear: drop=%b active=%b expected 0/1111", spawn_drop, ball_active);
    end
    adv_to(49);
    vectors++;
    if (ball_active[0] !== 1'b1 || ball_y[9:0] !== 10'd20 || misses !== 8'd0) begin
      errors++;
      $display("FAIL miss_at_end: act0=%b y0=%0d misses=%0d expected 1/20/0",
               ball_active[0], ball_y[9:0], misses);
    end
    adv_to(50);
    vectors++;
    if (ball_active !== 4'b1110 || misses !== 8'd1 || miss_pulse !== 1'b1) begin
      errors++;
      $display("FAIL miss_first: active=%b misses=%0d pulse=%b expected 1110/1/1",
               ball_active, misses, miss_pulse);
    end
    adv_to(51);
    vectors++;
    if (miss_pulse !== 1'b0) begin
      errors++;
      $display("FAIL miss_pulse_width: pulse=%b expected 0", miss_pulse);
    end
    adv_to(56);
    vectors++;
    if (ball_active !== 4'b1111 || ball_y[9:0] !== 10'd0) begin
      errors++;
      $display("FAIL respawn_slot0: active=%b y0=%0d expected 1111/0", ball_active, ball_y[9:0]);
    end
    adv_to(58);
    vectors++;
    if (misses !== 8'd2 || game_over !== 1'b0 || ball_active !== 4'b1101) begin
      errors++;
      $display("FAIL miss_second: misses=%0d over=%b active=%b expected 2/0/1101",
               misses, game_over, ball_active);
    end
    adv_to(66);
    vectors++;
    if (misses !== 8'd3 || game_over !== 1'b1 || ball_active !== 4'b1011) begin
      errors++;
      $display("FAIL game_over: misses=%0d over=%b active=%b expected 3/1/1011",
               misses, game_over, ball_active);
    end
    adv_to(76);
    vectors++;
    if (ball_active !== 4'b1011 || ball_y[9:0] !== 10'd5 || ball_y[19:10] !== 10'd1 ||
        ball_y[39:30] !== 10'd17) begin
      errors++;
      $display("FAIL over_freeze: active=%b y0=%0d y1=%0d y3=%0d expected 1011/5/1/17",
               ball_active, ball_y[9:0], ball_y[19:10], ball_y[39:30]);
    end
    vectors++;
    if ({hit_pulse, miss_pulse, spawn_drop} !== 3'b000) begin
      errors++;
      $display("FAIL over_pulses: pulses=%b%b%b expected 000", hit_pulse, miss_pulse, spawn_drop);
    end
    start = 1'b1;
    adv_to(77);
    start = 1'b0;
    vectors++;
    if ({game_over, score, misses, ball_active} !== 29'd0) begin
      errors++;
      $display("FAIL restart: over=%b score=%0d misses=%0d active=%b expected all zero",
               game_over, score, misses, ball_active);
    end
  endtask

  task automatic test_hit();
    start_game();
    adv_to(20);
    button = 1'b1;
    adv_to(21);
    vectors++;
    if (score !== 16'd0 || hit_pulse !== 1'b0 || ball_active !== 4'b0011) begin
      errors++;
      $display("FAIL press_empty_zone: score=%0d hit=%b active=%b expected 0/0/0011",
               score, hit_pulse, ball_active);
    end
    button = 1'b0;
    adv_to(26);
    button = 1'b1;
    adv_to(28);
    vectors++;
    if (score !== 16'd0 || ball_active[0] !== 1'b1 || ball_y[9:0] !== 10'd10) begin
      errors++;
      $display("FAIL press_above_zone: score=%0d act0=%b y0=%0d expected 0/1/10",
               score, ball_active[0], ball_y[9:0]);
    end
    button = 1'b0;
    adv_to(32);
    button = 1'b1;
    adv_to(33);
    vectors++;
    if (ball_active !== 4'b1110 || score !== 16'd1 || hit_pulse !== 1'b1 ||
        ball_y[19:10] !== 10'd8) begin
      errors++;
      $display("FAIL hit_single: active=%b score=%0d hit=%b y1=%0d expected 1110/1/1/8",
               ball_active, score, hit_pulse, ball_y[19:10]);
    end
    for (int k = 34; k <= 40; k++) begin
      adv_to(k);
      vectors++;
      if (hit_pulse !== 1'b0 || score !== 16'd1) begin
        errors++;
        $display("FAIL hold_no_rehit t=%0d: hit=%b score=%0d expected 0/1", t, hit_pulse, score);
      end
    end
    vectors++;
    if (ball_active !== 4'b1111 || ball_y[19:10] !== 10'd12) begin
      errors++;
      $display("FAIL hold_state: active=%b y1=%0d expected 1111/12", ball_active, ball_y[19:10]);
    end
    button = 1'b0;
    adv_to(44);
    button = 1'b1;
    adv_to(45);
    vectors++;
    if (ball_active !== 4'b1101 || ball_y[29:20] !== 10'd10 || score !== 16'd2 ||
        hit_pulse !== 1'b1) begin
      errors++;
      $display("FAIL hit_zone_bottom: active=%b y2=%0d score=%0d hit=%b expected 1101/10/2/1",
               ball_active, ball_y[29:20], score, hit_pulse);
    end
    button = 1'b0;
    adv_to(60);
    button = 1'b1;
    adv_to(61);
    vectors++;
    if (ball_active !== 4'b0111 || ball_y[9:0] !== 10'd10 || score !== 16'd3) begin
      errors++;
      $display("FAIL hit_largest_y: active=%b y0=%0d score=%0d expected 0111/10/3",
               ball_active, ball_y[9:0], score);
    end
    button = 1'b0;
  endtask

  task automatic test_zone_edge();
    start_game();
    adv_to(38);
    button = 1'b1;
    adv_to(39);
    vectors++;
    if (ball_active !== 4'b1101 || ball_y[9:0] !== 10'd15 || score !== 16'd1) begin
      errors++;
      $display("FAIL zone_below_excluded: active=%b y0=%0d score=%0d expected 1101/15/1",
               ball_active, ball_y[9:0], score);
    end
    button = 1'b0;
  endtask

  task automatic test_async_reset();
    start_game();
    adv_to(20);
    vectors++;
    if (ball_active !== 4'b0011) begin
      errors++;
      $display("FAIL pre_reset: active=%b expected 0011", ball_active);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({ball_active, ball_y, score, misses, game_over, hit_pulse, miss_pulse, spawn_drop} !== 72'd0) begin
      errors++;
      $display("FAIL async_reset: active=%b y=%h score=%0d misses=%0d over=%b expected all zero",
               ball_active, ball_y, score, misses, game_over);
    end
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (ball_active !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle: active=%b expected 0000", ball_active);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    button = 1'b0;
    test_reset();
    test_spawn();
    test_miss_and_over();
    test_hit();
    test_zone_edge();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ball_scheduler.md
Name: ball_scheduler

Overview:
Sequences the falling-ball gameplay datapath. Owns a pool of 4 ball slots: spawns balls at a fixed tick interval, advances their Y positions on a divided tick, and judges button presses against the hit zone. Tracks score and misses, and ends the game after too many misses. Feeds per-slot Y/active to the pixel renderers and score/state to the display logic.

Parameters:
TICK_DIV, 500000, clk cycles per movement tick
SPAWN_TICKS, 40, movement ticks between spawn attempts
Y_START, 0, Y loaded into a newly spawned slot
Y_END, 779, Y at which an active ball counts as missed
ZONE_TOP, 400, hit zone upper bound, inclusive
ZONE_BOT, 475, hit zone lower bound, inclusive
MAX_MISSES, 8, miss count that forces game over

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level; sampled in IDLE/OVER to begin a game
button  in  1  player button, already synchronized to clk
ball_y  out  40  slot i Y at [10*i+9:10*i]
ball_active  out  4  slot i holds a live ball
score  out  16  hits this game, saturating
misses  out  8  misses this game
game_over  out  1  high in OVER
hit_pulse  out  1  1-cycle pulse per judged hit
miss_pulse  out  1  1-cycle pulse per miss (ball reaching Y_END)
spawn_drop  out  1  1-cycle pulse when a spawn finds no free slot

Behaviour:
- Reset (async): state=IDLE; all outputs, counters, ball_y, ball_active, and button history = 0.
- FSM: IDLE -(start)-> RUN; RUN -(misses reaches MAX_MISSES)-> OVER; OVER -(start)-> RUN.
- On IDLE->RUN or OVER->RUN: clear score, misses, slots, tick_cnt and spawn_cnt.
- In IDLE and OVER: nothing moves; slots hold their last values; no pulses.
- tick_cnt: counts 0..TICK_DIV-1 in RUN. tick is asserted in the cycle tick_cnt==TICK_DIV-1, then tick_cnt wraps to 0.
- Per tick, for each active slot:
  - If y==Y_END: clear active, misses+1, miss_pulse.
  - Otherwise: y+1.
- Several slots may miss on the same tick. misses adds their count in one step, and miss_pulse is a single pulse.
- Spawn: spawn_cnt advances on each tick. When it is SPAWN_TICKS-1 on a tick, it wraps to 0 and the spawn fires.
  - The spawn takes the lowest-index slot that was inactive at the start of the cycle, sets active=1 and y=Y_START.
  - If no slot was inactive: spawn_drop pulse, and the counter still wraps.
  - The first spawn occurs SPAWN_TICKS ticks after entering RUN.
- Button judging:
  - A press is a rising edge (button=1, previous sample 0), evaluated in RUN only.
  - Candidates are active slots with ZONE_TOP<=y<=ZONE_BOT, using y from the start of the cycle.
  - The winner is the candidate with the largest y; ties go to the lowest index.
  - The winner is cleared, score+1 (held at 16'hFFFF), and hit_pulse fires 1 cycle after the edge cycle (registered).
  - No candidate: no effect.
  - At most one hit per press.
- Same-cycle rules:
  - A hit slot is cleared even if a tick coincides; it is not advanced.
  - A slot freed by a hit or miss is not spawnable until the next cycle.
  - A miss pushing misses to MAX_MISSES moves to OVER on the next edge; spawns and hits from that same cycle still complete.
- Width rules: y is 10 bits; Y_END<=1023 and ZONE_BOT<Y_END are required. misses saturates at 255.
- reset asserted mid-game returns to IDLE immediately with all state cleared.

Test Plan:
Common bench parameters: TICK_DIV=2, SPAWN_TICKS=4, Y_END=20, ZONE 10..14, MAX_MISSES=3.
- Reset then start: ball_active=0000 for 7 cycles. Slot0 active with y=0 at tick 4, y=1 at tick 5. No pulses.
- Let slot0 fall untouched: when y==20 on a tick, slot0 clears, misses=1, and miss_pulse is high for 1 cycle.
- Press with slot0 y=12 and slot1 y=2: slot0 clears, slot1 unchanged, score=1, hit_pulse fires once. Holding button high produces no second hit.
- Two balls in zone, slot0 y=11 and slot1 y=13: press clears slot1 only. A press with zone empty leaves score unchanged.
- Fill 4 slots: the next spawn tick pulses spawn_drop and ball_active stays 1111. Three misses set game_over=1 and freeze all slots. start returns to RUN with score=0, misses=0, ball_active=0000.
- Assert reset mid-RUN between ticks: all outputs drop to 0 asynchronously, before the next clk edge.
